// File: rtl/score_display_pkg.sv
// score_display_pkg
//   Shared constants and types for the score display controller:
//   7-segment patterns ({g,f,e,d,c,b,a}, active-high), score limits,
//   conversion FSM state type and the capture-time score clamp.
package score_display_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SCORE_W    = 7;
    localparam int unsigned SCORE_MAX  = 99;
    localparam int unsigned BCD_W      = 8;
    localparam int unsigned DD_ITERS   = 7;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    function automatic logic [SCORE_W-1:0] clamp_score(input logic [SCORE_W-1:0] s);
        return (s > SCORE_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : s;
    endfunction

endpackage

// File: rtl/score_display_ctrl_seg7_encode.sv
// seg7_encode
//   Combinational BCD nibble to 7-segment pattern.
//   bcd   : 4-bit BCD digit (non-BCD codes show as 0)
//   blank : 1 = all segments off
//   seg   : {g,f,e,d,c,b,a}, inverted when INVERT_OUTPUT = 1
module seg7_encode #(
    parameter bit INVERT_OUTPUT = 1'b1
) (
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);
    import score_display_pkg::*;

    logic [6:0] pat;

    always_comb begin
        pat = SEG_0;
        if (blank) begin
            pat = SEG_BLANK;
        end else begin
            case (bcd)
                4'd0:    pat = SEG_0;
                4'd1:    pat = SEG_1;
                4'd2:    pat = SEG_2;
                4'd3:    pat = SEG_3;
                4'd4:    pat = SEG_4;
                4'd5:    pat = SEG_5;
                4'd6:    pat = SEG_6;
                4'd7:    pat = SEG_7;
                4'd8:    pat = SEG_8;
                4'd9:    pat = SEG_9;
                default: pat = SEG_0;
            endcase
        end
        seg = INVERT_OUTPUT ? ~pat : pat;
    end

endmodule

// File: rtl/score_display_ctrl.sv
// score_display_ctrl
//   Captures two player scores, converts each to two BCD digits with a
//   7-step sequential double-dabble, and time-multiplexes the four digits
//   onto a shared 7-segment bus.
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   score_a/b   : player scores, binary (clamped to 99 at capture)
//   score_valid : one-cycle capture strobe
//   busy        : conversion running or queued
//   seg         : registered segments {g,f,e,d,c,b,a}
//   an          : registered one-hot digit enables
//   Digit map: 0 = B ones, 1 = B tens, 2 = A ones, 3 = A tens.
module score_display_ctrl #(
    parameter bit          INVERT_OUTPUT = 1'b1,
    parameter bit          AN_ACTIVE_LOW = 1'b1,
    parameter int unsigned REFRESH_DIV   = 50000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] score_a,
    input  logic [6:0] score_b,
    input  logic       score_valid,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an
);
    import score_display_pkg::*;

    localparam int unsigned CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]  SEG_OFF  = INVERT_OUTPUT ? 7'h7F : 7'h00;
    localparam logic [3:0]  AN_OFF   = AN_ACTIVE_LOW ? 4'hF : 4'h0;
    localparam int unsigned DD_W     = BCD_W + SCORE_W;

    // ---------------- conversion ----------------
    state_t                 state;
    logic                   pending;
    logic [SCORE_W-1:0]     pend_a, pend_b;
    logic [DD_W-1:0]        dd_a, dd_b;
    logic [DD_W-1:0]        dd_a_next, dd_b_next;
    logic [2:0]             iter;
    logic [BCD_W-1:0]       disp_a, disp_b;
    logic                   last_iter;

    // Working register layout: {tens[14:11], ones[10:7], binary[6:0]}.
    // Scores are <= 99, so the tens nibble never needs a correction that
    // would carry out of the register.
    function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] v);
        logic [DD_W-1:0] t;
        t = v;
        if (t[10:7] >= 4'd5)  t[10:7]  = t[10:7]  + 4'd3;
        if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
        return t << 1;
    endfunction

    assign dd_a_next = dd_step(dd_a);
    assign dd_b_next = dd_step(dd_b);
    assign last_iter = (iter == 3'(DD_ITERS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            pending <= 1'b0;
            pend_a  <= '0;
            pend_b  <= '0;
            dd_a    <= '0;
            dd_b    <= '0;
            iter    <= '0;
            disp_a  <= '0;
            disp_b  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Fresh inputs take priority over a queued pair.
                    if (score_valid) begin
                        dd_a    <= {{BCD_W{1'b0}}, clamp_score(score_a)};
                        dd_b    <= {{BCD_W{1'b0}}, clamp_score(score_b)};
                        pending <= 1'b0;
                        iter    <= '0;
                        busy    <= 1'b1;
                        state   <= CONV;
                    end else if (pending) begin
                        dd_a    <= {{BCD_W{1'b0}}, pend_a};
                        dd_b    <= {{BCD_W{1'b0}}, pend_b};
                        pending <= 1'b0;
                        iter    <= '0;
                        busy    <= 1'b1;
                        state   <= CONV;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                CONV: begin
                    dd_a <= dd_a_next;
                    dd_b <= dd_b_next;
                    iter <= iter + 3'd1;
                    if (score_valid) begin
                        pending <= 1'b1;
                        pend_a  <= clamp_score(score_a);
                        pend_b  <= clamp_score(score_b);
                    end
                    if (last_iter) begin
                        disp_a <= dd_a_next[DD_W-1:SCORE_W];
                        disp_b <= dd_b_next[DD_W-1:SCORE_W];
                        state  <= IDLE;
                        // A queued pair starts on the next cycle, so busy
                        // stays up across the IDLE hand-over.
                        busy   <= pending | score_valid;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- scanner ----------------
    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       digit_idx;
    logic [3:0]       dig_bcd;
    logic             dig_tens;
    logic             dig_blank;
    logic [6:0]       seg_cur;
    logic [3:0]       an_onehot;
    logic [3:0]       an_cur;

    always_comb begin
        dig_bcd  = '0;
        dig_tens = 1'b0;
        case (digit_idx)
            2'd0: dig_bcd = disp_b[3:0];
            2'd1: begin dig_bcd = disp_b[7:4]; dig_tens = 1'b1; end
            2'd2: dig_bcd = disp_a[3:0];
            2'd3: begin dig_bcd = disp_a[7:4]; dig_tens = 1'b1; end
            default: dig_bcd = '0;
        endcase
        dig_blank = BLANK_LEADING && dig_tens && (dig_bcd == 4'd0);
    end

    seg7_encode #(
        .INVERT_OUTPUT(INVERT_OUTPUT)
    ) u_seg7_encode (
        .bcd  (dig_bcd),
        .blank(dig_blank),
        .seg  (seg_cur)
    );

    assign an_onehot = 4'b0001 << digit_idx;
    assign an_cur    = AN_ACTIVE_LOW ? ~an_onehot : an_onehot;

    // digit_idx names the digit loaded onto seg/an at the next wrap, so the
    // first wrap after reset lights digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            seg         <= SEG_OFF;
            an          <= AN_OFF;
        end else if (refresh_cnt == CNT_LAST) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
            seg         <= seg_cur;
            an          <= an_cur;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
module tb_score_display_ctrl;

    localparam int DIV_A = 3;
    localparam int DIV_B = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] score_a = '0;
    logic [6:0] score_b = '0;
    logic       score_valid = 1'b0;

    logic       busy_a, busy_b;
    logic [6:0] seg_a, seg_b;
    logic [3:0] an_a, an_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Default polarities, fast scan.
    score_display_ctrl #(
        .INVERT_OUTPUT(1'b1),
        .AN_ACTIVE_LOW(1'b1),
        .REFRESH_DIV(DIV_A),
        .BLANK_LEADING(1'b1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .score_a(score_a), .score_b(score_b),
        .score_valid(score_valid), .busy(busy_a), .seg(seg_a), .an(an_a)
    );

    // Active-high outputs, leading zero shown.
    score_display_ctrl #(
        .INVERT_OUTPUT(1'b0),
        .AN_ACTIVE_LOW(1'b0),
        .REFRESH_DIV(DIV_B),
        .BLANK_LEADING(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .score_a(score_a), .score_b(score_b),
        .score_valid(score_valid), .busy(busy_b), .seg(seg_b), .an(an_b)
    );

    // ---------------- reference model ----------------
    int   e;
    int   disp_a, disp_b, conv_a, conv_b, pend_a, pend_b, done_e;
    bit   active, pend;
    logic [6:0] exp_seg_a, exp_seg_b;
    logic [3:0] exp_an_a, exp_an_b;
    logic       exp_busy;

    function automatic logic [6:0] pattern(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [6:0] digit_pattern(input int k, input int va, input int vb,
                                                 input bit blank_lead);
        int v;
        bit tens;
        tens = (k == 1) || (k == 3);
        case (k)
            0: v = vb % 10;
            1: v = vb / 10;
            2: v = va % 10;
            default: v = va / 10;
        endcase
        if (tens && blank_lead && v == 0) return 7'b0000000;
        return pattern(v);
    endfunction

    function automatic int clamp(input logic [6:0] s);
        return (int'(s) > 99) ? 99 : int'(s);
    endfunction

    task automatic model_reset();
        e = 0; disp_a = 0; disp_b = 0; conv_a = 0; conv_b = 0;
        pend_a = 0; pend_b = 0; done_e = 0; active = 0; pend = 0;
        exp_seg_a = 7'h7F; exp_an_a = 4'hF;
        exp_seg_b = 7'h00; exp_an_b = 4'h0;
        exp_busy  = 1'b0;
    endtask

    task automatic start_conv(input int a, input int b);
        active = 1; conv_a = a; conv_b = b; done_e = e + 7; pend = 0;
    endtask

    // Called right after each rising edge; inputs are still those sampled.
    task automatic model_edge();
        logic [3:0] oh;
        int k;
        if (!rst_n) return;
        e++;
        if (e % DIV_A == 0) begin
            k = (e / DIV_A - 1) % 4;
            oh = 4'b0001 << k;
            exp_seg_a = ~digit_pattern(k, disp_a, disp_b, 1'b1);
            exp_an_a  = ~oh;
        end
        if (e % DIV_B == 0) begin
            k = (e / DIV_B - 1) % 4;
            oh = 4'b0001 << k;
            exp_seg_b = digit_pattern(k, disp_a, disp_b, 1'b0);
            exp_an_b  = oh;
        end
        if (!active) begin
            if (score_valid)  start_conv(clamp(score_a), clamp(score_b));
            else if (pend)    start_conv(pend_a, pend_b);
        end else begin
            if (score_valid) begin
                pend = 1; pend_a = clamp(score_a); pend_b = clamp(score_b);
            end
            if (e == done_e) begin
                disp_a = conv_a; disp_b = conv_b; active = 0;
            end
        end
        exp_busy = active || pend;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic check_all();
        check("seg_a",  {1'b0, seg_a},  {1'b0, exp_seg_a});
        check("an_a",   {4'b0, an_a},   {4'b0, exp_an_a});
        check("busy_a", {7'b0, busy_a}, {7'b0, exp_busy});
        check("seg_b",  {1'b0, seg_b},  {1'b0, exp_seg_b});
        check("an_b",   {4'b0, an_b},   {4'b0, exp_an_b});
        check("busy_b", {7'b0, busy_b}, {7'b0, exp_busy});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse(input logic [6:0] a, input logic [6:0] b);
        score_a = a; score_b = b; score_valid = 1'b1;
        step();
        score_valid = 1'b0;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic reset_now();
        #2 rst_n = 1'b0;
        #1;
        check("rst_seg_a", {1'b0, seg_a}, 8'h7F);
        check("rst_an_a",  {4'b0, an_a},  8'h0F);
        check("rst_seg_b", {1'b0, seg_b}, 8'h00);
        check("rst_an_b",  {4'b0, an_b},  8'h00);
        check("rst_busy",  {7'b0, busy_a}, 8'h00);
        model_reset();
        @(negedge clk);
        steps(2);
        rst_n = 1'b1;
    endtask

    int busy_cycles;
    int waited;

    initial begin
        model_reset();
        steps(3);
        rst_n = 1'b1;

        // First wraps after reset release: digit 0 with 0/0.
        steps(14);

        // Mid-scan reset.
        steps(1);
        reset_now();
        steps(DIV_A);
        check("first_wrap_an_a",  {4'b0, an_a},  8'h0E);
        check("first_wrap_seg_a", {1'b0, seg_a}, {1'b0, ~7'b0111111});

        // 42 / 7: busy for exactly seven cycles, then scan shows 7,blank,2,4.
        busy_cycles = 0;
        pulse(7'd42, 7'd7);
        if (busy_a) busy_cycles++;
        for (int i = 0; i < 11; i++) begin
            step();
            if (busy_a) busy_cycles++;
        end
        check("busy_len", 8'(busy_cycles), 8'd7);
        steps(16);

        // Saturation.
        pulse(7'd127, 7'd100);
        steps(24);

        // Overlap: 10 at cycle 0, 11 at cycle 2, 12 at cycle 4.
        pulse(7'd10, 7'd10);
        steps(1);
        pulse(7'd11, 7'd11);
        steps(1);
        pulse(7'd12, 7'd12);
        steps(30);

        // Back-to-back: valid arriving exactly on the finishing edge.
        pulse(7'd20, 7'd21);
        steps(6);
        pulse(7'd30, 7'd31);
        steps(20);

        // Single-digit score on the active-high instance: tens shown as 0.
        pulse(7'd5, 7'd5);
        steps(10);
        waited = 0;
        while (an_b !== 4'b0010 && waited < 20) begin
            step();
            waited++;
        end
        check("b_digit1_an",  {4'b0, an_b},  8'h02);
        check("b_digit1_seg", {1'b0, seg_b}, {1'b0, 7'b0111111});
        steps(8);

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            score_a = 7'($urandom_range(0, 127));
            score_b = 7'($urandom_range(0, 127));
            score_valid = ($urandom_range(0, 2) == 0);
            step();
            score_valid = 1'b0;
            steps(int'($urandom_range(0, 9)));
        end
        steps(20);

        // Reset mid-conversion: display returns to 0/0, pending lost.
        pulse(7'd33, 7'd44);
        steps(2);
        pulse(7'd55, 7'd66);
        reset_now();
        steps(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
